aes_ark_invmix_param: RTL

Parametrised AES decryption round step: XORs a round key from the expanded-key RAM into the state RAM, then optionally applies InvMixColumns, column by column, in place. It supports Rijndael block widths of NB = 4..8 columns and a runtime mode select. It sits in the AES datapath under the same ap_start/ap_done control as the other round-step blocks and replaces the fixed 4-column AddRoundKey+InvMixColumns block.

---
 rtl/aes_ark_pkg.sv | 39 +++
 rtl/aes_inv_mix_col.sv | 25 ++
 rtl/aes_ark_invmix_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_ark_pkg.sv
// -----------------------------------------------------------------------------
// aes_ark_pkg
// Shared definitions for the parametrised AddRoundKey / InvMixColumns step:
//   - state_t   : controller state encoding
//   - AES_POLY  : low byte of the Rijndael field polynomial x^8+x^4+x^3+x+1
//   - xtime     : multiply by x (0x02) in GF(2^8)
//   - gf_mul    : general GF(2^8) multiply (shift-and-add over xtime)
// -----------------------------------------------------------------------------
package aes_ark_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_CALC,
        ST_WR0,
        ST_WR1,
        ST_DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_mix_col.sv
// -----------------------------------------------------------------------------
// aes_inv_mix_col
// Purely combinational InvMixColumns on one 4-byte column.
//   col_in  : bytes b0..b3 (index 0 = row 0)
//   col_out : r_i = 0e*b_i ^ 0b*b_{i+1} ^ 0d*b_{i+2} ^ 09*b_{i+3}, indices mod 4
// -----------------------------------------------------------------------------
module aes_inv_mix_col
    import aes_ark_pkg::*;
(
    input  logic [3:0][7:0] col_in,
    output logic [3:0][7:0] col_out
);

    always_comb begin
        col_out[0] = gf_mul(8'h0E, col_in[0]) ^ gf_mul(8'h0B, col_in[1]) ^
                     gf_mul(8'h0D, col_in[2]) ^ gf_mul(8'h09, col_in[3]);
        col_out[1] = gf_mul(8'h0E, col_in[1]) ^ gf_mul(8'h0B, col_in[2]) ^
                     gf_mul(8'h0D, col_in[3]) ^ gf_mul(8'h09, col_in[0]);
        col_out[2] = gf_mul(8'h0E, col_in[2]) ^ gf_mul(8'h0B, col_in[3]) ^
                     gf_mul(8'h0D, col_in[0]) ^ gf_mul(8'h09, col_in[1]);
        col_out[3] = gf_mul(8'h0E, col_in[3]) ^ gf_mul(8'h0B, col_in[0]) ^
                     gf_mul(8'h0D, col_in[1]) ^ gf_mul(8'h09, col_in[2]);
    end

endmodule

// File: rtl/aes_ark_invmix_param.sv
// -----------------------------------------------------------------------------
// aes_ark_invmix_param
// AES decryption round step for NB = 4..8 columns: XOR a round key from the
// expanded-key RAM into the state RAM, then optionally InvMixColumns, one
// column at a time, in place.
//
// Ports
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   ap_start/done/idle/ready  block handshake
//   n                         round index (latched at start)
//   mode                      0 = AddRoundKey only, 1 = + InvMixColumns
//   key_err                   round key out of range (no RAM access done)
//   statemt_*0/1              dual-port state RAM (1-cycle read latency)
//   word_*0/1                 dual-port expanded-key RAM, read only
//
// Each column takes five cycles: RD0 (rows 0,1), RD1 (rows 2,3), CALC,
// WR0 (rows 0,1), WR1 (rows 2,3). All RAM outputs are decoded from the state
// register only, so an asynchronous reset silences them immediately.
// -----------------------------------------------------------------------------
module aes_ark_invmix_param
    import aes_ark_pkg::*;
#(
    parameter int NB        = 4,
    parameter int WORD_COLS = 120,
    parameter int SA_W      = 5,
    parameter int WA_W      = 9
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    input  logic            ap_start,
    output logic            ap_done,
    output logic            ap_idle,
    output logic            ap_ready,
    input  logic [3:0]      n,
    input  logic            mode,
    output logic            key_err,
    output logic [SA_W-1:0] statemt_address0,
    output logic            statemt_ce0,
    output logic            statemt_we0,
    output logic [31:0]     statemt_d0,
    input  logic [31:0]     statemt_q0,
    output logic [SA_W-1:0] statemt_address1,
    output logic            statemt_ce1,
    output logic            statemt_we1,
    output logic [31:0]     statemt_d1,
    input  logic [31:0]     statemt_q1,
    output logic [WA_W-1:0] word_address0,
    output logic            word_ce0,
    input  logic [31:0]     word_q0,
    output logic [WA_W-1:0] word_address1,
    output logic            word_ce1,
    input  logic [31:0]     word_q1
);

    // Key RAM row offsets: key byte (i, j) sits at i*WORD_COLS + j + NB*n.
    localparam logic [WA_W-1:0] ROW_OFF1 = WA_W'(WORD_COLS);
    localparam logic [WA_W-1:0] ROW_OFF2 = WA_W'(2 * WORD_COLS);
    localparam logic [WA_W-1:0] ROW_OFF3 = WA_W'(3 * WORD_COLS);
    localparam logic [3:0]      LAST_COL = 4'(NB - 1);

    state_t           state_q, state_d;
    logic [3:0]       col_q;
    logic             mode_q;
    logic             key_err_q;
    logic [WA_W-1:0]  key_base_q;   // NB*n, fixed for the whole run
    logic [3:0][31:0] x_q;          // state ^ key for the current column

    logic             key_oor;
    logic [SA_W-1:0]  col_base;
    logic [WA_W-1:0]  key_col;
    logic [3:0][7:0]  mix_in;
    logic [3:0][7:0]  mix_out;
    logic [3:0][31:0] wr_data;

    // Evaluated on the live n so the range decision is made in the start cycle.
    assign key_oor  = (NB * int'(n) + NB) > WORD_COLS;
    assign col_base = SA_W'({col_q, 2'b00});
    assign key_col  = key_base_q + WA_W'(col_q);
    assign key_err  = key_err_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ST_IDLE;
            col_q      <= '0;
            mode_q     <= 1'b0;
            key_err_q  <= 1'b0;
            key_base_q <= '0;
            x_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values; blocking would chain updates within the edge.
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (ap_start) begin
                        mode_q     <= mode;
                        key_base_q <= WA_W'(NB * int'(n));
                        col_q      <= '0;
                        key_err_q  <= key_oor;
                    end
                end
                ST_RD1: begin
                    x_q[0] <= statemt_q0 ^ word_q0;
                    x_q[1] <= statemt_q1 ^ word_q1;
                end
                ST_CALC: begin
                    x_q[2] <= statemt_q0 ^ word_q0;
                    x_q[3] <= statemt_q1 ^ word_q1;
                end
                ST_WR1:  col_q <= col_q + 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ap_start) state_d = key_oor ? ST_DONE : ST_RD0;
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_CALC;
            ST_CALC: state_d = ST_WR0;
            ST_WR0:  state_d = ST_WR1;
            ST_WR1:  state_d = (col_q == LAST_COL) ? ST_DONE : ST_RD0;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Only the low byte of each XORed word enters InvMixColumns.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mix_in[i]  = x_q[i][7:0];
            wr_data[i] = mode_q ? {24'h0, mix_out[i]} : x_q[i];
        end
    end

    aes_inv_mix_col u_inv_mix_col (
        .col_in  (mix_in),
        .col_out (mix_out)
    );

    always_comb begin
        // NOTE: every output is given a default before the case, so states
        // that leave a port untouched cannot infer a latch.
        ap_idle          = (state_q == ST_IDLE);
        ap_done          = 1'b0;
        ap_ready         = 1'b0;
        statemt_address0 = '0;
        statemt_address1 = '0;
        statemt_ce0      = 1'b0;
        statemt_ce1      = 1'b0;
        statemt_we0      = 1'b0;
        statemt_we1      = 1'b0;
        statemt_d0       = '0;
        statemt_d1       = '0;
        word_address0    = '0;
        word_address1    = '0;
        word_ce0         = 1'b0;
        word_ce1         = 1'b0;
        case (state_q)
            ST_RD0: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_address0 = col_base;
                statemt_address1 = col_base + SA_W'(1);
                word_ce0         = 1'b1;
                word_ce1         = 1'b1;
                word_address0    = key_col;
                word_address1    = key_col + ROW_OFF1;
            end
            ST_RD1: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_address0 = col_base + SA_W'(2);
                statemt_address1 = col_base + SA_W'(3);
                word_ce0         = 1'b1;
                word_ce1         = 1'b1;
                word_address0    = key_col + ROW_OFF2;
                word_address1    = key_col + ROW_OFF3;
            end
            ST_WR0: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_address0 = col_base;
                statemt_address1 = col_base + SA_W'(1);
                statemt_d0       = wr_data[0];
                statemt_d1       = wr_data[1];
            end
            ST_WR1: begin
                statemt_ce0      = 1'b1;
                statemt_ce1      = 1'b1;
                statemt_we0      = 1'b1;
                statemt_we1      = 1'b1;
                statemt_address0 = col_base + SA_W'(2);
                statemt_address1 = col_base + SA_W'(3);
                statemt_d0       = wr_data[2];
                statemt_d1       = wr_data[3];
            end
            ST_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
